memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Shares the core's single memory bus between two requesters: instruction fetch (read-only) and the data port driven by the control unit's mem_rd_en/mem_wr_en/mem_byte_en (loads/stores).
- Sits between the pipeline datapath and the memory/bus interconnect.
- Arbitrates with data priority and a bounded anti-starvation counter.
- Holds a grant for exactly one bus transaction, until the memory acknowledges it.

Parameters:
- DATA_SIZE, 64, bus data width in bits.
- ADDR_SIZE, 64, bus address width in bits.
- BYTE_NUM, DATA_SIZE/8, byte-enable width.
- MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch is waiting; range 1..15.

Ports:
- clock  in  1  core clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- inst_rd_en  in  1  fetch request strobe; held until inst_ack.
- inst_addr  in  ADDR_SIZE  fetch address.
- inst_rd_data  out  DATA_SIZE  fetch read data; valid only while inst_ack=1.
- inst_ack  out  1  fetch completion, one cycle.
- data_rd_en  in  1  load request strobe.
- data_wr_en  in  1  store request strobe (never asserted together with data_rd_en).
- data_addr  in  ADDR_SIZE  load/store address.
- data_wr_data  in  DATA_SIZE  store data.
- data_byte_en  in  BYTE_NUM  byte lanes.
- data_rd_data  out  DATA_SIZE  load data; valid only while data_ack=1.
- data_ack  out  1  load/store completion, one cycle.
- mem_rd_en  out  1  bus read strobe.
- mem_wr_en  out  1  bus write strobe.
- mem_addr  out  ADDR_SIZE  bus address.
- mem_wr_data  out  DATA_SIZE  bus write data.
- mem_byte_en  out  BYTE_NUM  bus byte lanes; all ones for fetch.
- mem_rd_data  in  DATA_SIZE  bus read data.
- mem_ack  in  1  bus completion.
- busy  out  1  high in any non-idle state.

Behaviour:
- Reset (async, reset_n=0): state=ArbIdle, streak=0, drop flag=0. All outputs 0 immediately; any in-flight transaction is abandoned.
- States: ArbIdle, ArbInst, ArbData.
- Arbitration happens only in ArbIdle. Let data_req = data_rd_en|data_wr_en.
  - data_req && !(inst_rd_en && streak==MAX_DATA_STREAK): go to ArbData; streak += 1 if inst_rd_en else 0.
  - Otherwise, if inst_rd_en: go to ArbInst; streak = 0.
  - No request: stay in ArbIdle; streak holds.
- Latency: a request sampled in ArbIdle at cycle N drives mem strobes at N+1. Minimum turnaround is req->ack 2 cycles (mem_ack at N+1).
- Bus drive: in ArbInst/ArbData, mem_* are driven combinationally from the granted requester's inputs. mem_rd_en/mem_wr_en are gated by the requester's current strobe. In ArbIdle all mem_* = 0.
- Completion: in a busy state, a mem_ack cycle does two things:
  - asserts the granted requester's ack combinationally in the same cycle;
  - returns the state to ArbIdle on the next edge. This leaves one idle bubble between transactions.
- Read data passes through (inst_rd_data/data_rd_data = mem_rd_data) only while the matching ack is high; otherwise 0.
- Strobe withdrawn mid-grant: the state holds until mem_ack (a bus transaction is not abortable), and the drop flag is set. The matching ack is suppressed (not forwarded) and the flag clears on return to ArbIdle.
- The ungranted requester never sees ack. Its inputs do not affect the mem_* outputs.
- mem_ack in ArbIdle is ignored.
- Bus write data: mem_wr_data = data_wr_data in ArbData, else 0.
- Streak: 4-bit counter that saturates at MAX_DATA_STREAK. It resets to 0 whenever fetch is granted or no fetch is pending at a data grant.

Decomposition:
- memory_arbiter_pkg holds:
  - arb_state_t enum {ArbIdle, ArbInst, ArbData};
  - the streak counter width constant.
- No sub-module; the streak counter and FSM are local.

Test Plan:
- Single fetch: inst_rd_en=1, addr 0x100, memory acks 2 cycles after strobe with 0xDEAD -> mem_rd_en=1 at N+1, inst_ack=1 with inst_rd_data=0xDEAD on ack cycle, data_ack never 1.
- Simultaneous fetch and store (addr 0x200, byte_en 0x0F, data 0x55) -> ArbData first, mem_wr_en=1 with mem_byte_en=0x0F. After its ack, one bubble, then the fetch is granted with mem_byte_en=0xFF.
- Starvation bound: data_req and inst_rd_en held continuously, MAX_DATA_STREAK=4 -> exactly 4 data transactions, then 1 fetch, then data again.
- Strobe drop: grant fetch, deassert inst_rd_en before mem_ack -> mem_rd_en falls, state stays ArbInst, and the later mem_ack produces no inst_ack. Return to ArbIdle follows.
- Reset mid-transaction: in ArbData, pull reset_n low asynchronously -> mem_wr_en/mem_rd_en/busy drop to 0 the same cycle, and the first request after release is arbitrated from ArbIdle with streak=0.
- Spurious mem_ack in ArbIdle -> no inst_ack/data_ack, state unchanged.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// rtl/memory_arbiter_pkg.sv - shared types and constants for the memory bus arbiter
package memory_arbiter_pkg;

    // Arbiter grant state: idle, fetch granted, load/store granted
    typedef enum logic [1:0] {
        ArbIdle = 2'd0,
        ArbInst = 2'd1,
        ArbData = 2'd2
    } arb_state_t;

    // Width of the consecutive-data-grant counter (holds 0..15)
    localparam int STREAK_W = 4;

endpackage

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - two-requester memory bus arbiter with data priority and fetch anti-starvation
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int DATA_SIZE       = 64,
    parameter int ADDR_SIZE       = 64,
    parameter int BYTE_NUM        = DATA_SIZE / 8,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 inst_rd_en,
    input  logic [ADDR_SIZE-1:0] inst_addr,
    output logic [DATA_SIZE-1:0] inst_rd_data,
    output logic                 inst_ack,
    input  logic                 data_rd_en,
    input  logic                 data_wr_en,
    input  logic [ADDR_SIZE-1:0] data_addr,
    input  logic [DATA_SIZE-1:0] data_wr_data,
    input  logic [BYTE_NUM-1:0]  data_byte_en,
    output logic [DATA_SIZE-1:0] data_rd_data,
    output logic                 data_ack,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0] mem_wr_data,
    output logic [BYTE_NUM-1:0]  mem_byte_en,
    input  logic [DATA_SIZE-1:0] mem_rd_data,
    input  logic                 mem_ack,
    output logic                 busy
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    arb_state_t          state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                drop_q, drop_d;

    logic data_req;
    logic inst_starved;
    logic granted_strobe;

    assign data_req     = data_rd_en | data_wr_en;
    assign inst_starved = inst_rd_en && (streak_q == STREAK_MAX);

    // Current strobe of whichever requester owns the bus; low in idle
    always_comb begin
        granted_strobe = 1'b0;
        case (state_q)
            ArbInst: granted_strobe = inst_rd_en;
            ArbData: granted_strobe = data_req;
            default: granted_strobe = 1'b0;
        endcase
    end

    // State, streak counter and drop flag registers; reset abandons any transaction
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ArbIdle;
            streak_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            drop_q   <= drop_d;
        end
    end

    // Next-state: arbitrate only in idle, release the grant on mem_ack
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        drop_d   = drop_q;
        case (state_q)
            ArbIdle: begin
                drop_d = 1'b0;
                if (data_req && !inst_starved) begin
                    state_d = ArbData;
                    if (inst_rd_en) begin
                        streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + 1'b1;
                    end else begin
                        streak_d = '0;
                    end
                end else if (inst_rd_en) begin
                    state_d  = ArbInst;
                    streak_d = '0;
                end
            end
            ArbInst, ArbData: begin
                if (mem_ack) begin
                    state_d = ArbIdle;
                    drop_d  = 1'b0;
                end else if (!granted_strobe) begin
                    // A bus transaction cannot be aborted: hold the grant, remember to swallow its ack
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = ArbIdle;
                drop_d  = 1'b0;
            end
        endcase
    end

    // Outputs: steer the granted requester onto the bus and route the ack/read data back
    always_comb begin
        mem_rd_en    = 1'b0;
        mem_wr_en    = 1'b0;
        mem_addr     = '0;
        mem_wr_data  = '0;
        mem_byte_en  = '0;
        inst_ack     = 1'b0;
        data_ack     = 1'b0;
        inst_rd_data = '0;
        data_rd_data = '0;
        busy         = 1'b0;
        case (state_q)
            ArbInst: begin
                busy        = 1'b1;
                mem_rd_en   = inst_rd_en;
                mem_addr    = inst_addr;
                mem_byte_en = '1;
                inst_ack    = mem_ack && granted_strobe && !drop_q;
                if (inst_ack) begin
                    inst_rd_data = mem_rd_data;
                end
            end
            ArbData: begin
                busy        = 1'b1;
                mem_rd_en   = data_rd_en;
                mem_wr_en   = data_wr_en;
                mem_addr    = data_addr;
                mem_wr_data = data_wr_data;
                mem_byte_en = data_byte_en;
                data_ack    = mem_ack && granted_strobe && !drop_q;
                if (data_ack) begin
                    data_rd_data = mem_rd_data;
                end
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed self-checking bench for memory_arbiter
module tb_memory_arbiter;

    logic        clock;
    logic        reset_n;
    logic        inst_rd_en;
    logic [63:0] inst_addr;
    logic [63:0] inst_rd_data;
    logic        inst_ack;
    logic        data_rd_en;
    logic        data_wr_en;
    logic [63:0] data_addr;
    logic [63:0] data_wr_data;
    logic [7:0]  data_byte_en;
    logic [63:0] data_rd_data;
    logic        data_ack;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [63:0] mem_addr;
    logic [63:0] mem_wr_data;
    logic [7:0]  mem_byte_en;
    logic [63:0] mem_rd_data;
    logic        mem_ack;
    logic        busy;

    int checks;
    int errors;

    memory_arbiter #(
        .DATA_SIZE(64),
        .ADDR_SIZE(64),
        .BYTE_NUM(8),
        .MAX_DATA_STREAK(4)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .inst_rd_en(inst_rd_en),
        .inst_addr(inst_addr),
        .inst_rd_data(inst_rd_data),
        .inst_ack(inst_ack),
        .data_rd_en(data_rd_en),
        .data_wr_en(data_wr_en),
        .data_addr(data_addr),
        .data_wr_data(data_wr_data),
        .data_byte_en(data_byte_en),
        .data_rd_data(data_rd_data),
        .data_ack(data_ack),
        .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_byte_en(mem_byte_en),
        .mem_rd_data(mem_rd_data),
        .mem_ack(mem_ack),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        inst_rd_en   = 1'b0;
        inst_addr    = 64'h0;
        data_rd_en   = 1'b0;
        data_wr_en   = 1'b0;
        data_addr    = 64'h0;
        data_wr_data = 64'h0;
        data_byte_en = 8'h00;
        mem_rd_data  = 64'h0;
        mem_ack      = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        #3;
        checks++;
        if ({busy, mem_rd_en, mem_wr_en, inst_ack, data_ack} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, mem_rd_en, mem_wr_en, inst_ack, data_ack});
        end
        checks++;
        if (mem_addr !== 64'h0 || mem_byte_en !== 8'h00 || mem_wr_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_bus: addr %h be %h wd %h expected all zero", mem_addr, mem_byte_en, mem_wr_data);
        end
        cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_single_fetch();
        do_reset();
        inst_rd_en = 1'b1;
        inst_addr  = 64'h100;
        #1;
        checks++;
        if (mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL fetch_latency: mem_rd_en %b expected 0 in request cycle", mem_rd_en);
        end
        cyc();
        checks++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 64'h100 || mem_byte_en !== 8'hFF || busy !== 1'b1) begin
            errors++;
            $display("FAIL fetch_drive: rd %b addr %h be %h busy %b expected 1 100 ff 1", mem_rd_en, mem_addr, mem_byte_en, busy);
        end
        checks++;
        if (inst_ack !== 1'b0 || inst_rd_data !== 64'h0) begin
            errors++;
            $display("FAIL fetch_preack: ack %b data %h expected 0 0", inst_ack, inst_rd_data);
        end
        cyc();
        mem_ack     = 1'b1;
        mem_rd_data = 64'hDEAD;
        #1;
        checks++;
        if (inst_ack !== 1'b1 || inst_rd_data !== 64'hDEAD) begin
            errors++;
            $display("FAIL fetch_ack: ack %b data %h expected 1 dead", inst_ack, inst_rd_data);
        end
        checks++;
        if (data_ack !== 1'b0 || data_rd_data !== 64'h0) begin
            errors++;
            $display("FAIL fetch_no_data_ack: data_ack %b data %h expected 0 0", data_ack, data_rd_data);
        end
        cyc();
        clear_inputs();
        #1;
        checks++;
        if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL fetch_release: busy %b rd %b expected 0 0", busy, mem_rd_en);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        inst_rd_en   = 1'b1;
        inst_addr    = 64'h300;
        data_wr_en   = 1'b1;
        data_addr    = 64'h200;
        data_byte_en = 8'h0F;
        data_wr_data = 64'h55;
        cyc();
        checks++;
        if (mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0 || mem_byte_en !== 8'h0F || mem_addr !== 64'h200 || mem_wr_data !== 64'h55) begin
            errors++;
            $display("FAIL sim_store: wr %b rd %b be %h addr %h wd %h expected 1 0 0f 200 55", mem_wr_en, mem_rd_en, mem_byte_en, mem_addr, mem_wr_data);
        end
        mem_ack = 1'b1;
        #1;
        checks++;
        if (data_ack !== 1'b1 || inst_ack !== 1'b0) begin
            errors++;
            $display("FAIL sim_store_ack: data_ack %b inst_ack %b expected 1 0", data_ack, inst_ack);
        end
        cyc();
        mem_ack    = 1'b0;
        data_wr_en = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL sim_bubble: busy %b rd %b expected 0 0", busy, mem_rd_en);
        end
        cyc();
        checks++;
        if (mem_rd_en !== 1'b1 || mem_byte_en !== 8'hFF || mem_addr !== 64'h300 || mem_wr_data !== 64'h0) begin
            errors++;
            $display("FAIL sim_fetch: rd %b be %h addr %h wd %h expected 1 ff 300 0", mem_rd_en, mem_byte_en, mem_addr, mem_wr_data);
        end
        mem_ack     = 1'b1;
        mem_rd_data = 64'h1234;
        #1;
        checks++;
        if (inst_ack !== 1'b1 || inst_rd_data !== 64'h1234 || data_rd_data !== 64'h0) begin
            errors++;
            $display("FAIL sim_fetch_ack: ack %b idata %h ddata %h expected 1 1234 0", inst_ack, inst_rd_data, data_rd_data);
        end
        cyc();
        clear_inputs();
    endtask

    task automatic test_starvation();
        int exp_inst[6];
        exp_inst = '{0, 0, 0, 0, 1, 0};
        do_reset();
        inst_rd_en   = 1'b1;
        inst_addr    = 64'h400;
        data_wr_en   = 1'b1;
        data_addr    = 64'h500;
        data_byte_en = 8'h3C;
        for (int i = 0; i < 6; i++) begin
            cyc();
            checks++;
            if (mem_rd_en !== exp_inst[i][0] || mem_wr_en !== !exp_inst[i][0]) begin
                errors++;
                $display("FAIL starve_grant%0d: rd %b wr %b expected inst=%0d", i, mem_rd_en, mem_wr_en, exp_inst[i]);
            end
            mem_ack = 1'b1;
            #1;
            checks++;
            if (inst_ack !== exp_inst[i][0] || data_ack !== !exp_inst[i][0]) begin
                errors++;
                $display("FAIL starve_ack%0d: inst_ack %b data_ack %b expected inst=%0d", i, inst_ack, data_ack, exp_inst[i]);
            end
            cyc();
            mem_ack = 1'b0;
        end
        clear_inputs();
        cyc();
    endtask

    task automatic test_strobe_drop();
        do_reset();
        inst_rd_en = 1'b1;
        inst_addr  = 64'h600;
        cyc();
        checks++;
        if (mem_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL drop_grant: rd %b expected 1", mem_rd_en);
        end
        inst_rd_en = 1'b0;
        #1;
        checks++;
        if (mem_rd_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_strobe: rd %b busy %b expected 0 1", mem_rd_en, busy);
        end
        cyc();
        inst_rd_en = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1 || mem_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL drop_hold: busy %b rd %b expected 1 1", busy, mem_rd_en);
        end
        mem_ack     = 1'b1;
        mem_rd_data = 64'hBEEF;
        #1;
        checks++;
        if (inst_ack !== 1'b0 || inst_rd_data !== 64'h0) begin
            errors++;
            $display("FAIL drop_ack: ack %b data %h expected 0 0", inst_ack, inst_rd_data);
        end
        cyc();
        clear_inputs();
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_release: busy %b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        inst_rd_en   = 1'b1;
        data_wr_en   = 1'b1;
        data_addr    = 64'h700;
        data_byte_en = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            cyc();
            mem_ack = 1'b1;
            cyc();
            mem_ack = 1'b0;
        end
        cyc();
        checks++;
        if (mem_wr_en !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rmid_grant: wr %b busy %b expected 1 1", mem_wr_en, busy);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async: wr %b rd %b busy %b expected 0 0 0", mem_wr_en, mem_rd_en, busy);
        end
        cyc();
        reset_n = 1'b1;
        cyc();
        checks++;
        if (mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL rmid_streak: wr %b rd %b expected data grant 1 0", mem_wr_en, mem_rd_en);
        end
        clear_inputs();
        do_reset();
    endtask

    task automatic test_spurious_ack();
        do_reset();
        mem_ack     = 1'b1;
        mem_rd_data = 64'hCAFE;
        #1;
        checks++;
        if (inst_ack !== 1'b0 || data_ack !== 1'b0 || inst_rd_data !== 64'h0 || data_rd_data !== 64'h0) begin
            errors++;
            $display("FAIL spur_ack: iack %b dack %b idata %h ddata %h expected 0 0 0 0", inst_ack, data_ack, inst_rd_data, data_rd_data);
        end
        cyc();
        checks++;
        if (busy !== 1'b0 || mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL spur_state: busy %b rd %b wr %b expected 0 0 0", busy, mem_rd_en, mem_wr_en);
        end
        clear_inputs();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_strobe_drop();
        test_reset_mid();
        test_spurious_ack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
